// File: rtl/core_axi_pkg.sv
// Shared types and AXI encodings for the single-outstanding CPU-to-AXI master bridge.
package core_axi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4,
    RESP   = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'h0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/core_axi_master.sv
// Single-outstanding AXI4 master: one CPU load/store becomes one single-beat AXI transaction.
// Optional build macro CORE_AXI_MST_POSTED_WRITE_EN: stores respond after AW+W, B drains in background.
module core_axi_master
  import core_axi_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] MST_ID     = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
  output logic                    post_err,
`endif
  output state_e                  dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic err_q, err_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic req_ready_q, req_ready_d, rready_q, rready_d;
  logic bready_q, bready_d, resp_valid_q, resp_valid_d;
  logic b_pend_q, b_pend_d;
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
  logic post_err_q, post_err_d;
`endif

  // Every channel transfers on a cycle where its valid and ready are both 1 at the clock edge;
  // a valid, once raised, holds its payload stable until that transfer.
  logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, resp_hs, aw_all, w_all;
  assign accept  = req_valid && req_ready_q;
  assign ar_hs   = arvalid_q && arready;
  assign r_hs    = rvalid && rready_q;
  assign aw_hs   = awvalid_q && awready;
  assign w_hs    = wvalid_q && wready;
  assign b_hs    = bvalid && bready_q;
  assign resp_hs = resp_valid_q && resp_ready;
  assign aw_all  = aw_done_q || aw_hs;
  assign w_all   = w_done_q || w_hs;

  // IDs are not checked: only one transaction is ever in flight.
  logic unused_inputs;
  assign unused_inputs = ^{bid, rid, bresp[0], rresp[0], req_addr[1:0]};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wstrb_q      <= '0;
      err_q        <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      b_pend_q     <= 1'b0;
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
      post_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      wstrb_q      <= wstrb_d;
      err_q        <= err_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      rready_q     <= rready_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      b_pend_q     <= b_pend_d;
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
      post_err_q   <= post_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)  state_d = req_write ? WR_AWW : RD_AR;
      RD_AR:   if (ar_hs)   state_d = RD_R;
      RD_R:    if (r_hs)    state_d = RESP;
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
      WR_AWW:  if (aw_all && w_all) state_d = RESP;
`else
      WR_AWW:  if (aw_all && w_all) state_d = WR_B;
`endif
      WR_B:    if (b_hs)    state_d = RESP;
      RESP:    if (resp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid_d = awvalid_q && !aw_hs;
    wvalid_d  = wvalid_q && !w_hs;
    arvalid_d = arvalid_q && !ar_hs;
    aw_done_d = aw_done_q || aw_hs;
    w_done_d  = w_done_q || w_hs;
    b_pend_d  = 1'b0;
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
    post_err_d = post_err_q;
    b_pend_d   = b_pend_q && !b_hs;
    if (state_q == WR_AWW && aw_all && w_all) b_pend_d = 1'b1;
    if (b_pend_q && b_hs && resp_is_err(bresp)) post_err_d = 1'b1;
`endif
    if (accept) begin
      addr_d    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
      wdata_d   = req_wdata;
      wstrb_d   = req_wstrb;
      rdata_d   = '0;
      err_d     = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      arvalid_d = !req_write;
      awvalid_d = req_write;
      wvalid_d  = req_write;
    end
    if (state_q == RD_R && r_hs) begin
      rdata_d = rdata;
      // A single-beat read must end with rlast; anything else is a protocol error.
      err_d   = resp_is_err(rresp) || !rlast;
    end
    if (state_q == WR_B && b_hs) err_d = resp_is_err(bresp);
  end

  // Ready/valid outputs are registered from the next state so no AXI input reaches an output combinationally.
  always_comb begin
    req_ready_d  = (state_d == IDLE) && !b_pend_d;
    rready_d     = (state_d == RD_R);
    bready_d     = (state_d == WR_B) || b_pend_d;
    resp_valid_d = (state_d == RESP);
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign awid    = MST_ID;
  assign awaddr  = addr_q;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign awvalid = awvalid_q;

  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid_q;
  assign wvalid  = wvalid_q;

  assign bready  = bready_q;

  assign arid    = MST_ID;
  assign araddr  = addr_q;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = arvalid_q;

  assign rready  = rready_q;

`ifdef CORE_AXI_MST_POSTED_WRITE_EN
  assign post_err = post_err_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_axi_master.sv
// Directed bench for core_axi_master: hand-written AXI slave responses, expected CPU responses in a queue.
module tb_core_axi_master;
  import core_axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  awid, awlen, arid, arlen;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0;
  logic [3:0]  wstrb;
  logic [3:0]  bid = '0, rid = '0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, rready;
  logic        post_err;
  state_e      dbg_state;

  core_axi_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
    .post_err(post_err),
`endif
    .dbg_state(dbg_state)
  );

`ifndef CORE_AXI_MST_POSTED_WRITE_EN
  assign post_err = 1'b0;
`endif

  // Clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard: {resp_err, resp_rdata} per expected CPU response
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic        post_err_exp = 1'b0;
  logic        b_outstanding = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic sig_sel(input int w);
    case (w)
      0:       return req_ready;
      1:       return resp_valid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int w, input string tag);
    int n = 0;
    while (sig_sel(w) !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check(tag, {31'b0, sig_sel(w)}, 32'd1);
  endtask

  // Drivers (all called on a negedge; inputs change only there)
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    wait_hi(0, "req_ready_wait");
    @(negedge aclk);
    req_valid = 1'b0;
  endtask

  task automatic get_resp(input int hold);
    logic [32:0] e;
    wait_hi(1, "resp_valid_wait");
    check("sb_depth", exp_q.size(), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, e[31:0]);
      check("hold_err", {31'b0, resp_err}, {31'b0, e[32]});
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge aclk);
    end
    check("resp_rdata", resp_rdata, e[31:0]);
    check("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
    check("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
    resp_ready = 1'b1;
    @(negedge aclk);
    resp_ready = 1'b0;
    check("resp_valid_drop", {31'b0, resp_valid}, 32'd0);
    check("req_ready_after", {31'b0, req_ready}, {31'b0, !b_outstanding});
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_a, input int ar_wait,
                          input logic [31:0] d, input logic [1:0] rr, input logic rl, input int hold);
    exp_q.push_back({rr[1] | ~rl, d});
    do_req(1'b0, a, 32'h0, 4'h0);
    check("arvalid_up", {31'b0, arvalid}, 32'd1);
    check("araddr", araddr, exp_a);
    check("arlen", {28'b0, arlen}, 32'd0);
    check("arsize", {29'b0, arsize}, 32'd2);
    check("arburst", {30'b0, arburst}, 32'd1);
    check("arid", {28'b0, arid}, 32'd0);
    check("awvalid_on_load", {31'b0, awvalid}, 32'd0);
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge aclk);
      check("arvalid_hold", {31'b0, arvalid}, 32'd1);
      check("araddr_hold", araddr, exp_a);
    end
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    check("arvalid_drop", {31'b0, arvalid}, 32'd0);
    check("rready_up", {31'b0, rready}, 32'd1);
    rvalid = 1'b1; rdata = d; rresp = rr; rlast = rl; rid = 4'h5;
    @(negedge aclk);
    rvalid = 1'b0; rdata = 32'h0; rlast = 1'b0;
    check("rready_drop", {31'b0, rready}, 32'd0);
    get_resp(hold);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] exp_a, input logic [31:0] d,
                           input logic [3:0] s, input int w_wait, input int aw_wait,
                           input int b_wait, input logic [1:0] br);
    int last;
    last = (w_wait > aw_wait) ? w_wait : aw_wait;
    do_req(1'b1, a, d, s);
    check("awaddr", awaddr, exp_a);
    check("wdata", wdata, d);
    check("wstrb", {28'b0, wstrb}, {28'b0, s});
    check("awlen", {28'b0, awlen}, 32'd0);
    check("awsize", {29'b0, awsize}, 32'd2);
    check("awburst", {30'b0, awburst}, 32'd1);
    check("arvalid_on_store", {31'b0, arvalid}, 32'd0);
    for (int c = 0; c <= last + 1; c++) begin
      check("wvalid", {31'b0, wvalid}, {31'b0, c <= w_wait});
      check("wlast", {31'b0, wlast}, {31'b0, c <= w_wait});
      check("awvalid", {31'b0, awvalid}, {31'b0, c <= aw_wait});
      if (c <= last) begin
        check("bready_early", {31'b0, bready}, 32'd0);
        check("resp_early", {31'b0, resp_valid}, 32'd0);
      end
      wready = (c == w_wait);
      awready = (c == aw_wait);
      @(negedge aclk);
    end
    wready = 1'b0; awready = 1'b0;
`ifdef CORE_AXI_MST_POSTED_WRITE_EN
    b_outstanding = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    get_resp(0);
    for (int i = 0; i < b_wait; i++) begin
      check("posted_bready", {31'b0, bready}, 32'd1);
      check("posted_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge aclk);
    end
    bvalid = 1'b1; bresp = br; bid = 4'h7;
    @(negedge aclk);
    bvalid = 1'b0; bresp = 2'b00;
    b_outstanding = 1'b0;
    post_err_exp = post_err_exp | br[1];
    check("posted_req_ready_back", {31'b0, req_ready}, 32'd1);
    check("posted_bready_drop", {31'b0, bready}, 32'd0);
    check("post_err", {31'b0, post_err}, {31'b0, post_err_exp});
`else
    for (int i = 0; i < b_wait; i++) begin
      check("bready_wait", {31'b0, bready}, 32'd1);
      check("resp_before_b", {31'b0, resp_valid}, 32'd0);
      @(negedge aclk);
    end
    bvalid = 1'b1; bresp = br; bid = 4'h7;
    @(negedge aclk);
    bvalid = 1'b0; bresp = 2'b00;
    check("bready_drop", {31'b0, bready}, 32'd0);
    exp_q.push_back({br[1], 32'h0});
    get_resp(0);
`endif
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_arvalid"}, {31'b0, arvalid}, 32'd0);
    check({tag, "_rready"}, {31'b0, rready}, 32'd0);
    check({tag, "_awvalid"}, {31'b0, awvalid}, 32'd0);
    check({tag, "_wvalid"}, {31'b0, wvalid}, 32'd0);
    check({tag, "_bready"}, {31'b0, bready}, 32'd0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_state"}, {29'b0, dbg_state}, {29'b0, IDLE});
    check({tag, "_post_err"}, {31'b0, post_err}, 32'd0);
  endtask

  initial begin
    #3;
    check_quiet("rst");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("req_ready_post_rst", {31'b0, req_ready}, 32'd1);

    axi_read(32'h0000_0010, 32'h0000_0010, 2, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 0);
    axi_write(32'h0000_0024, 32'h0000_0024, 32'h1234_5678, 4'b0011, 0, 3, 2, RESP_OKAY);
    axi_read(32'h0000_0033, 32'h0000_0030, 0, 32'hCAFE_0001, RESP_SLVERR, 1'b1, 0);
    axi_write(32'h0000_0100, 32'h0000_0100, 32'hA5A5_5A5A, 4'hF, 2, 0, 0, RESP_DECERR);
    axi_write(32'h0000_0009, 32'h0000_0008, 32'h0F0F_0F0F, 4'b1100, 1, 1, 1, RESP_OKAY);
    axi_read(32'h0000_0044, 32'h0000_0044, 1, 32'h0BAD_F00D, RESP_OKAY, 1'b0, 0);
    axi_read(32'h0000_0200, 32'h0000_0200, 0, 32'h0000_55AA, RESP_EXOKAY, 1'b1, 5);
    axi_write(32'h0000_0050, 32'h0000_0050, 32'h7777_0000, 4'hF, 0, 0, 6, RESP_SLVERR);

    // Reset while waiting in RD_R
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    check("rd_r_reached", {29'b0, dbg_state}, {29'b0, RD_R});
    #2 aresetn = 1'b0;
    #1;
    check_quiet("async_rst");
    post_err_exp = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    rvalid = 1'b1; rdata = 32'h1111_2222; rlast = 1'b1;
    @(negedge aclk);
    rvalid = 1'b0; rdata = 32'h0; rlast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);
      @(negedge aclk);
    end
    check("req_ready_after_rst", {31'b0, req_ready}, 32'd1);
    axi_read(32'h0000_0080, 32'h0000_0080, 1, 32'h89AB_CDEF, RESP_OKAY, 1'b1, 0);

    check("sb_empty_end", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
